// File: rtl/wordle_pkg.sv
// wordle_pkg
// Shared constants for the Wordle guess scorer: score codes, the ASCII
// letter range, the scorer FSM state encoding and the default word length.
package wordle_pkg;

  localparam int N_LETTERS_DEF = 5;
  localparam int N_ALPHA       = 26;

  localparam logic [1:0] SCORE_GREEN  = 2'b10;
  localparam logic [1:0] SCORE_YELLOW = 2'b01;
  localparam logic [1:0] SCORE_GREY   = 2'b00;

  localparam logic [7:0] ASCII_A = 8'h41;
  localparam logic [7:0] ASCII_Z = 8'h5A;

  // One-hot scorer states
  typedef enum logic [3:0] {
    ST_IDLE   = 4'b0001,
    ST_GREEN  = 4'b0010,
    ST_YELLOW = 4'b0100,
    ST_DONE   = 4'b1000
  } state_t;

endpackage

// File: rtl/wordle_letter_index.sv
// wordle_letter_index
// Combinational map of one ASCII byte to an alphabet index.
// Ports:
//   i_char  - ASCII byte
//   o_idx   - 0..25 for 'A'..'Z', forced to 0 for any other byte
//   o_valid - high when i_char is an upper-case letter
module wordle_letter_index
  import wordle_pkg::*;
(
  input  logic [7:0] i_char,
  output logic [4:0] o_idx,
  output logic       o_valid
);

  logic w_valid;

  assign w_valid = (i_char >= ASCII_A) && (i_char <= ASCII_Z);
  assign o_valid = w_valid;
  // Zeroing the index for non-letters keeps counter reads in range.
  assign o_idx   = w_valid ? 5'(i_char - ASCII_A) : 5'd0;

endmodule

// File: rtl/wordle_guess_scorer.sv
// wordle_guess_scorer
// Scores a committed guess against the word of the day using the two-pass
// algorithm (greens first while counting unmatched answer letters, then
// yellows left to right consuming those counts). One letter per clock.
// Ports:
//   Clk, reset      - clock, asynchronous active-high reset
//   start           - request to score, only accepted in IDLE
//   guess, answer   - ASCII words, letter 0 in the MSBs
//   busy            - high from the cycle after start is accepted through DONE
//   done            - one-cycle pulse, result/win valid from then on
//   result          - 2 bits per letter, letter 0 in the MSBs
//   win             - every letter green
module wordle_guess_scorer
  import wordle_pkg::*;
#(
  parameter int N_LETTERS = N_LETTERS_DEF,
  parameter int CNT_W     = 3
)(
  input  logic                   Clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [8*N_LETTERS-1:0] guess,
  input  logic [8*N_LETTERS-1:0] answer,
  output logic                   busy,
  output logic                   done,
  output logic [2*N_LETTERS-1:0] result,
  output logic                   win
);

  // idx must reach N_LETTERS: the YELLOW pass spends one extra step
  // publishing the result, which sets the 2*N+1 edge latency.
  localparam int IDX_W = $clog2(N_LETTERS + 1);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [8*N_LETTERS-1:0] r_guess;
  logic [8*N_LETTERS-1:0] r_answer;
  logic [IDX_W-1:0]       r_idx;
  logic [N_LETTERS-1:0]   r_green;
  logic [CNT_W-1:0]       r_cnt    [N_ALPHA];
  logic [1:0]             r_score  [N_LETTERS];
  logic [1:0]             r_result [N_LETTERS];
  logic                   r_win;

  logic [7:0] w_g_char;
  logic [7:0] w_a_char;
  logic       w_green_bit;
  logic [4:0] w_g_idx;
  logic [4:0] w_a_idx;
  logic       w_g_valid;
  logic       w_a_valid;
  logic       w_last_green;
  logic       w_last_yellow;

  // Letter select at idx; nothing matches when idx == N_LETTERS.
  always_comb begin
    w_g_char    = '0;
    w_a_char    = '0;
    w_green_bit = 1'b0;
    for (int k = 0; k < N_LETTERS; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_g_char    = r_guess[8*(N_LETTERS-1-k) +: 8];
        w_a_char    = r_answer[8*(N_LETTERS-1-k) +: 8];
        w_green_bit = r_green[k];
      end
    end
  end

  wordle_letter_index u_guess_idx (
    .i_char  (w_g_char),
    .o_idx   (w_g_idx),
    .o_valid (w_g_valid)
  );

  wordle_letter_index u_answer_idx (
    .i_char  (w_a_char),
    .o_idx   (w_a_idx),
    .o_valid (w_a_valid)
  );

  assign w_last_green  = (r_idx == IDX_W'(N_LETTERS - 1));
  assign w_last_yellow = (r_idx == IDX_W'(N_LETTERS));

  // State register and datapath
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_guess  <= '0;
      r_answer <= '0;
      r_idx    <= '0;
      r_green  <= '0;
      r_win    <= 1'b0;
      for (int c = 0; c < N_ALPHA; c++) r_cnt[c] <= '0;
      for (int k = 0; k < N_LETTERS; k++) begin
        r_score[k]  <= SCORE_GREY;
        r_result[k] <= SCORE_GREY;
      end
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_guess  <= guess;
            r_answer <= answer;
            r_idx    <= '0;
            r_green  <= '0;
            r_win    <= 1'b0;
            for (int c = 0; c < N_ALPHA; c++) r_cnt[c] <= '0;
            for (int k = 0; k < N_LETTERS; k++) begin
              r_score[k]  <= SCORE_GREY;
              r_result[k] <= SCORE_GREY;
            end
          end
        end
        ST_GREEN: begin
          if (w_g_valid && (w_g_char == w_a_char))
            r_green[r_idx] <= 1'b1;
          else if (w_a_valid)
            r_cnt[w_a_idx] <= r_cnt[w_a_idx] + CNT_W'(1);
          r_idx <= w_last_green ? '0 : r_idx + IDX_W'(1);
        end
        ST_YELLOW: begin
          if (w_last_yellow) begin
            for (int k = 0; k < N_LETTERS; k++) r_result[k] <= r_score[k];
            r_win <= &r_green;
          end else if (w_green_bit) begin
            r_score[r_idx] <= SCORE_GREEN;
          end else if (w_g_valid && (r_cnt[w_g_idx] != '0)) begin
            r_score[r_idx] <= SCORE_YELLOW;
            r_cnt[w_g_idx] <= r_cnt[w_g_idx] - CNT_W'(1);
          end else begin
            r_score[r_idx] <= SCORE_GREY;
          end
          r_idx <= r_idx + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (start)         w_state_nxt = ST_GREEN;
      ST_GREEN:  if (w_last_green)  w_state_nxt = ST_YELLOW;
      ST_YELLOW: if (w_last_yellow) w_state_nxt = ST_DONE;
      ST_DONE:                      w_state_nxt = ST_IDLE;
      default:                      w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy   = (r_state != ST_IDLE);
    done   = (r_state == ST_DONE);
    win    = r_win;
    result = '0;
    for (int k = 0; k < N_LETTERS; k++)
      result[2*(N_LETTERS-1-k) +: 2] = r_result[k];
  end

endmodule

// File: tb/tb_wordle_guess_scorer.sv
module tb_wordle_guess_scorer;

  logic        Clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [39:0] guess = '0;
  logic [39:0] answer = '0;
  logic        busy;
  logic        done;
  logic [9:0]  result;
  logic        win;

  wordle_guess_scorer dut (
    .Clk    (Clk),
    .reset  (reset),
    .start  (start),
    .guess  (guess),
    .answer (answer),
    .busy   (busy),
    .done   (done),
    .result (result),
    .win    (win)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int total  = 0;
  int passes = 0;

  typedef struct {
    logic [9:0] res;
    logic       win;
    int         start_edge;
  } exp_t;
  exp_t q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: compares every done pulse against the oldest expectation.
  logic prev_done = 1'b0;
  always @(negedge Clk) begin
    if (done) begin
      check("done_single_cycle", {31'd0, prev_done}, 32'd0);
      if (q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("result", {22'd0, result}, {22'd0, e.res});
        check("win", {31'd0, win}, {31'd0, e.win});
        check("latency", cyc - e.start_edge, 32'd11);
      end
    end
    prev_done = done;
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 40) begin
      @(negedge Clk);
      n++;
    end
    check("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  task automatic push_exp(input logic [9:0] r, input logic w, input int se);
    exp_t e;
    e.res = r; e.win = w; e.start_edge = se;
    q.push_back(e);
  endtask

  task automatic run_score(input logic [39:0] g, input logic [39:0] a,
                           input logic [9:0] r, input logic w);
    @(negedge Clk);
    guess = g; answer = a; start = 1'b1;
    push_exp(r, w, cyc + 1);
    @(negedge Clk);
    start = 1'b0;
    guess = 40'h5A5A5A5A5A;
    check("busy_after_start", {31'd0, busy}, 32'd1);
    check("result_cleared", {22'd0, result}, 32'd0);
    wait_idle();
  endtask

  int se;
  int busy_low;

  initial begin
    #12;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", {22'd0, result}, 32'd0);
    check("rst_win", {31'd0, win}, 32'd0);
    @(negedge Clk);
    reset = 1'b0;
    repeat (2) @(negedge Clk);

    run_score("ROBOT", "ROBOT", 10'b1010101010, 1'b1);
    run_score("BOBBY", "ABBOT", 10'b0101100000, 1'b0);
    run_score("EERIE", "RENEW", 10'b0110010000, 1'b0);
    run_score("ROB0T", "ROBOT", 10'b1010100010, 1'b0);

    // start re-asserted at edge 4 with another guess is ignored
    @(negedge Clk);
    guess = "BOBBY"; answer = "ABBOT"; start = 1'b1;
    se = cyc + 1;
    push_exp(10'b0101100000, 1'b0, se);
    @(negedge Clk);
    start = 1'b0;
    busy_low = 0;
    while (cyc < se + 11) begin
      if (cyc == se + 3) begin
        guess = "ROBOT"; answer = "ROBOT"; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (!busy) busy_low++;
      @(negedge Clk);
    end
    start = 1'b0;
    check("busy_continuous", busy_low, 32'd0);
    wait_idle();

    // reset asserted at edge 6 of a scoring
    @(negedge Clk);
    guess = "EERIE"; answer = "RENEW"; start = 1'b1;
    se = cyc + 1;
    @(negedge Clk);
    start = 1'b0;
    while (cyc < se + 5) @(negedge Clk);
    reset = 1'b1;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_result", {22'd0, result}, 32'd0);
    check("midrst_win", {31'd0, win}, 32'd0);
    @(negedge Clk);
    reset = 1'b0;
    run_score("EERIE", "RENEW", 10'b0110010000, 1'b0);

    // start held high: back-to-back scorings, second begins 13 edges later
    @(negedge Clk);
    guess = "ROBOT"; answer = "ROBOT"; start = 1'b1;
    se = cyc + 1;
    push_exp(10'b1010101010, 1'b1, se);
    push_exp(10'b0101100000, 1'b0, se + 13);
    @(negedge Clk);
    guess = "BOBBY"; answer = "ABBOT";
    while (cyc < se + 13) @(negedge Clk);
    @(negedge Clk);
    start = 1'b0;
    wait_idle();

    repeat (3) @(negedge Clk);
    check("scoreboard_empty", q.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
